spi_command_framer: RTL

// - Parses the SPI byte stream into framed bus transactions for the MOS SPI interface.
// - Sits between the SPI byte layer (rx byte + valid strobe, tx byte) and the core register map.
// - Frames commands as: instruction, 24-bit address, then either 32-bit write data (WRITE)
//   or 32-bit read data returned to the MCU (READ).
// - Drives instruction/address/value buses with one-cycle strobes; serialises read results MSB first.

---
 rtl/spi_command_framer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_command_framer.sv
// Frames the SPI byte stream into register-map write/read transactions.
// Optional WRITE checksum byte enabled by defining SPI_FRAME_CHECKSUM_EN.
module spi_command_framer #(
   parameter logic [7:0] INSTR_WRITE = 8'h01,
   parameter logic [7:0] INSTR_READ  = 8'h02,
   parameter logic [7:0] IDLE_TX     = 8'h00
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        spi_cs_i,
   input  logic        spi_rx_valid_i,
   input  logic [7:0]  spi_rx_byte_i,
   input  logic [31:0] result_i,
   output logic [7:0]  instruction_o,
   output logic [23:0] address_o,
   output logic [31:0] value_o,
   output logic        wr_strobe_o,
   output logic        rd_strobe_o,
   output logic [7:0]  spi_tx_byte_o,
   output logic        frame_err_o
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StWsum,
      StRdata,
      StDrain
   } state_e;

   state_e      state_q, state_d;
   logic        cs_meta_q, cs_s_q;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  instr_q, instr_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] value_q, value_d;
   // Read data not yet on tx: the tx register holds the current byte, this the remaining three.
   logic [23:0] sreg_q, sreg_d;
   logic [7:0]  tx_q, tx_d;
   logic        err_q, err_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic        cap_q;
   logic        rx;
`ifdef SPI_FRAME_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif

   assign rx = spi_rx_valid_i & ~cs_s_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cs_meta_q <= 1'b1;
         cs_s_q    <= 1'b1;
         cnt_q     <= 2'd0;
         instr_q   <= 8'h00;
         addr_q    <= 24'h0;
         value_q   <= 32'h0;
         sreg_q    <= 24'h0;
         tx_q      <= IDLE_TX;
         err_q     <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         cap_q     <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
         sum_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         cs_meta_q <= spi_cs_i;
         cs_s_q    <= cs_meta_q;
         cnt_q     <= cnt_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
         value_q   <= value_d;
         sreg_q    <= sreg_d;
         tx_q      <= tx_d;
         err_q     <= err_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cap_q     <= rd_q;
`ifdef SPI_FRAME_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      value_d = value_q;
      sreg_d  = sreg_q;
      tx_d    = tx_q;
      err_d   = err_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (cs_s_q) begin
         // Chip select high aborts whatever frame is in flight.
         state_d = StIdle;
         cnt_d   = 2'd0;
         tx_d    = IDLE_TX;
         if (state_q == StAddr || state_q == StWdata || state_q == StWsum) begin
            err_d = 1'b1;
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (rx) begin
                  instr_d = spi_rx_byte_i;
                  cnt_d   = 2'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
                  sum_d   = spi_rx_byte_i;
`endif
                  if (spi_rx_byte_i == INSTR_WRITE || spi_rx_byte_i == INSTR_READ) begin
                     state_d = StAddr;
                  end else begin
                     state_d = StDrain;
                     err_d   = 1'b1;
                  end
               end
            end
            StAddr: begin
               if (rx) begin
                  addr_d = {addr_q[15:0], spi_rx_byte_i};
                  cnt_d  = cnt_q + 2'd1;
`ifdef SPI_FRAME_CHECKSUM_EN
                  sum_d  = sum_q ^ spi_rx_byte_i;
`endif
                  if (cnt_q == 2'd2) begin
                     cnt_d = 2'd0;
                     if (instr_q == INSTR_WRITE) begin
                        state_d = StWdata;
                     end else begin
                        rd_d    = 1'b1;
                        state_d = StRdata;
                     end
                  end
               end
            end
            StWdata: begin
               if (rx) begin
                  value_d = {value_q[23:0], spi_rx_byte_i};
                  cnt_d   = cnt_q + 2'd1;
`ifdef SPI_FRAME_CHECKSUM_EN
                  sum_d   = sum_q ^ spi_rx_byte_i;
`endif
                  if (cnt_q == 2'd3) begin
                     cnt_d = 2'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
                     state_d = StWsum;
`else
                     wr_d    = 1'b1;
                     state_d = StDrain;
`endif
                  end
               end
            end
`ifdef SPI_FRAME_CHECKSUM_EN
            StWsum: begin
               if (rx) begin
                  if (spi_rx_byte_i == sum_q) begin
                     wr_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = StDrain;
               end
            end
`endif
            StRdata: begin
               if (cap_q) begin
                  tx_d   = result_i[31:24];
                  sreg_d = result_i[23:0];
               end else if (rx) begin
                  cnt_d = cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     cnt_d   = 2'd0;
                     tx_d    = IDLE_TX;
                     state_d = StDrain;
                  end else begin
                     tx_d   = sreg_q[23:16];
                     sreg_d = {sreg_q[15:0], 8'h00};
                  end
               end
            end
            StDrain: begin
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign instruction_o = instr_q;
   assign address_o     = addr_q;
   assign value_o       = value_q;
   assign wr_strobe_o   = wr_q;
   assign rd_strobe_o   = rd_q;
   assign spi_tx_byte_o = tx_q;
   assign frame_err_o   = err_q;

endmodule
